video_path_sequencer: RTL
=========================

Name: video_path_sequencer

Overview:
- Sequences the video output path around signal acquisition and format changes.
- Mutes the video output enable while sync is absent or unstable.
- Locks the detected video format only after it has been stable for a set number of frames, then registers the Y/G normalize decision from the locked format.
- Sits between signal_detector/video_format_detector/monitor_interface and the top-level video_oe_x, norm_y_g and LED outputs.

Parameters:
- STABLE_FRAMES, 3: consecutive vsync edges with identical non-zero format required to lock.
- MUTE_CYCLES, 500000: clocks the output stays muted before acquisition starts (10 ms at 50 MHz).
- VSYNC_TIMEOUT, 2500000: clocks without a vsync edge before the lock or acquisition is abandoned (50 ms).
- HD_THRESHOLD, 8'h05: video_format values above this count as HD (tri-level sync).

Ports:
- clk_50mhz_in, input, 1: system clock, 50 MHz.
- reset_x, input, 1: asynchronous active-low reset.
- signal_present_in, input, 1: from signal_detector; 1 = hsync activity present.
- vsync_in_x, input, 1: polarity-normalized vsync, active low, asynchronous to clock.
- video_format_in, input, 8: from video_format_detector; 0 = unknown.
- rgb_comp_x, input, 1: 0 = component, 1 = RGB, from monitor_interface.
- int_ext_x, input, 1: sync source select, same encoding as monitor_interface output.
- apt_on, input, 1: aperture on, from monitor_interface.
- video_oe_x_in, input, 1: host-requested video output enable, active low.
- video_oe_x_out, output, 1: gated video output enable, active low.
- norm_y_g, output, 1: normalize Y/G DC offset.
- format_locked, output, 1: 1 while in LOCKED.
- locked_format, output, 8: format captured at lock.
- relock_count, output, 8: number of lock events, saturates at 255.

Behaviour:
- Reset values: video_oe_x_out=1, norm_y_g=0, format_locked=0, locked_format=0, relock_count=0, state=NO_SIGNAL, all counters cleared.
- Vsync handling: vsync_in_x passes a 2-FF synchronizer. vsync_edge is a 1-cycle pulse on the synchronized 1->0 transition.
  - Latency: 3 clocks from the pin edge.
- Timeout counter: cleared on vsync_edge and on every state entry; otherwise increments and saturates. tmo = (count == VSYNC_TIMEOUT-1).
- State NO_SIGNAL: when signal_present_in=1, go to MUTE and load the mute counter.
- State MUTE:
  - Mute counter counts MUTE_CYCLES clocks.
  - At the end, go to ACQUIRE: candidate=video_format_in, frame_cnt=0.
- State ACQUIRE, on each vsync_edge:
  - If video_format_in==candidate and candidate!=0: frame_cnt++.
  - Otherwise: candidate=video_format_in, frame_cnt=0.
  - When frame_cnt reaches STABLE_FRAMES: go to LOCKED, locked_format=candidate, relock_count++ (saturating).
  - On tmo: go to MUTE and reload the mute counter.
- State LOCKED:
  - At a vsync_edge with video_format_in!=locked_format: go to MUTE.
  - On tmo: go to MUTE.
  - locked_format holds until the next lock.
- Priority: signal_present_in=0 forces NO_SIGNAL from any state, with counters cleared. This beats vsync_edge, tmo and mute completion. If vsync_edge and tmo occur in the same cycle, vsync_edge wins.
- video_oe_x_out:
  - Registered.
  - Equals video_oe_x_in in LOCKED, with 1-clock latency.
  - Equals 1 in every other state.
  - Goes to 1 on the first clock after leaving LOCKED.
- norm_y_g, registered, updated every clock:
  - apt_on=1: norm_y_g=1 in any state.
  - Otherwise in LOCKED: norm_y_g = (rgb_comp_x==0) ? (locked_format > HD_THRESHOLD) : (int_ext_x==1).
  - Otherwise outside LOCKED: hold the previous value.
- format_locked is the registered state==LOCKED, valid the same cycle as video_oe_x_out starts following.
- Reset asserted mid-operation: immediate return to reset values, no glitch beyond the asynchronous clear.

Decomposition:
- Shared package bkm_video_pkg holds:
  - state encoding (NO_SIGNAL=2'd0, MUTE=2'd1, ACQUIRE=2'd2, LOCKED=2'd3);
  - FORMAT_UNKNOWN=8'h00;
  - HD_THRESHOLD default.
- Sub-module sync_edge_detect: 2-FF synchronizer plus falling-edge pulse. It is reusable for hsync and the back buttons.

Test Plan:
Bench parameters are STABLE_FRAMES=3, MUTE_CYCLES=16, VSYNC_TIMEOUT=200, vsync period 100 clocks.
- Clean lock: reset low 5 clks then high; signal_present_in=1; format 8'h07 with vsync -> LOCKED on the 3rd counted edge after MUTE; locked_format=8'h07; relock_count=1; video_oe_x_out follows video_oe_x_in=0 after 1 clk; norm_y_g=1 with rgb_comp_x=0, apt_on=0.
- Unstable format: formats 2,3,2,3 on alternate edges -> stays in ACQUIRE, video_oe_x_out=1; hold at 8'h02 -> LOCKED, norm_y_g=0 (component, SD).
- Format change while locked: LOCKED at 8'h02, then format 8'h09 at a vsync edge -> video_oe_x_out=1 next clock; 16-clk MUTE; relock at 8'h09; relock_count=2; norm_y_g updates 0->1 only on entering LOCKED.
- Vsync loss: stop vsync while LOCKED -> MUTE after 200 clks, video_oe_x_out=1; a vsync edge on the timeout cycle keeps LOCKED.
- Signal loss priority: drop signal_present_in in the same cycle as the lock edge -> NO_SIGNAL, format_locked=0, relock_count unchanged.
- Overrides and saturation: apt_on=1 in NO_SIGNAL -> norm_y_g=1 next clk; 260 forced relocks -> relock_count=255.

Source files
------------

// File: rtl/bkm_video_pkg.sv
// rtl/bkm_video_pkg.sv - shared state encoding and constants for the video output path
package bkm_video_pkg;

  typedef enum logic [1:0] {
    NO_SIGNAL = 2'd0,
    MUTE      = 2'd1,
    ACQUIRE   = 2'd2,
    LOCKED    = 2'd3
  } vps_state_e;

  localparam logic [7:0] FORMAT_UNKNOWN       = 8'h00;
  localparam logic [7:0] HD_THRESHOLD_DEFAULT = 8'h05;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-FF synchronizer with registered falling-edge pulse
module sync_edge_detect #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle-level reset keeps a released reset from looking like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= IDLE_LEVEL;
      sync_q     <= IDLE_LEVEL;
      prev_q     <= IDLE_LEVEL;
      fall_pulse <= 1'b0;
    end else begin
      meta_q     <= async_in;
      sync_q     <= meta_q;
      prev_q     <= sync_q;
      fall_pulse <= prev_q & ~sync_q;
    end
  end

endmodule

// File: rtl/video_path_sequencer.sv
// rtl/video_path_sequencer.sv - mutes video output until sync is stable and the format is locked
module video_path_sequencer
  import bkm_video_pkg::*;
#(
  parameter int         STABLE_FRAMES = 3,
  parameter int         MUTE_CYCLES   = 500000,
  parameter int         VSYNC_TIMEOUT = 2500000,
  parameter logic [7:0] HD_THRESHOLD  = HD_THRESHOLD_DEFAULT
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  input  logic       signal_present_in,
  input  logic       vsync_in_x,
  input  logic [7:0] video_format_in,
  input  logic       rgb_comp_x,
  input  logic       int_ext_x,
  input  logic       apt_on,
  input  logic       video_oe_x_in,
  output logic       video_oe_x_out,
  output logic       norm_y_g,
  output logic       format_locked,
  output logic [7:0] locked_format,
  output logic [7:0] relock_count
);

  localparam int MW = $clog2(MUTE_CYCLES + 1);
  localparam int TW = $clog2(VSYNC_TIMEOUT + 1);
  localparam int FW = $clog2(STABLE_FRAMES + 1);
  localparam logic [MW-1:0] MUTE_LOAD  = MW'(MUTE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(VSYNC_TIMEOUT - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(STABLE_FRAMES - 1);

  vps_state_e    state, state_d;
  logic [MW-1:0] mute_cnt, mute_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic [FW-1:0] frame_cnt, frame_d;
  logic [7:0]    cand, cand_d;
  logic [7:0]    lf_d, rc_d;
  logic          oe_d, norm_d;
  logic          vsync_edge;
  logic          tmo;

  sync_edge_detect #(.IDLE_LEVEL(1'b1)) u_vsync_sync (
    .clk        (clk_50mhz_in),
    .rst_n      (reset_x),
    .async_in   (vsync_in_x),
    .fall_pulse (vsync_edge)
  );

  assign tmo = (tmo_cnt == TMO_MAX);

  always_comb begin
    state_d = state;
    mute_d  = mute_cnt;
    tmo_d   = tmo ? tmo_cnt : tmo_cnt + TW'(1);
    frame_d = frame_cnt;
    cand_d  = cand;
    lf_d    = locked_format;
    rc_d    = relock_count;

    case (state)
      NO_SIGNAL: begin
        if (signal_present_in) begin
          state_d = MUTE;
          mute_d  = MUTE_LOAD;
        end
      end
      MUTE: begin
        if (mute_cnt == '0) begin
          state_d = ACQUIRE;
          cand_d  = video_format_in;
          frame_d = '0;
        end else begin
          mute_d = mute_cnt - MW'(1);
        end
      end
      ACQUIRE: begin
        // A vsync edge is proof of life, so it outranks a coincident timeout.
        if (vsync_edge) begin
          if (video_format_in == cand && cand != FORMAT_UNKNOWN) begin
            if (frame_cnt == FRAME_LAST) begin
              state_d = LOCKED;
              lf_d    = cand;
              rc_d    = sat_inc8(relock_count);
              frame_d = '0;
            end else begin
              frame_d = frame_cnt + FW'(1);
            end
          end else begin
            cand_d  = video_format_in;
            frame_d = '0;
          end
        end else if (tmo) begin
          state_d = MUTE;
          mute_d  = MUTE_LOAD;
        end
      end
      LOCKED: begin
        if (vsync_edge) begin
          if (video_format_in != locked_format) begin
            state_d = MUTE;
            mute_d  = MUTE_LOAD;
          end
        end else if (tmo) begin
          state_d = MUTE;
          mute_d  = MUTE_LOAD;
        end
      end
      default: state_d = NO_SIGNAL;
    endcase

    if (vsync_edge || state_d != state) tmo_d = '0;

    // Signal loss aborts everything, including a lock decided this same cycle.
    if (!signal_present_in) begin
      state_d = NO_SIGNAL;
      mute_d  = '0;
      tmo_d   = '0;
      frame_d = '0;
      cand_d  = FORMAT_UNKNOWN;
      lf_d    = locked_format;
      rc_d    = relock_count;
    end

    oe_d = (state_d == LOCKED) ? video_oe_x_in : 1'b1;
    if (apt_on)
      norm_d = 1'b1;
    else if (state_d == LOCKED)
      norm_d = rgb_comp_x ? int_ext_x : (lf_d > HD_THRESHOLD);
    else
      norm_d = norm_y_g;
  end

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state          <= NO_SIGNAL;
      mute_cnt       <= '0;
      tmo_cnt        <= '0;
      frame_cnt      <= '0;
      cand           <= FORMAT_UNKNOWN;
      locked_format  <= FORMAT_UNKNOWN;
      relock_count   <= 8'd0;
      video_oe_x_out <= 1'b1;
      norm_y_g       <= 1'b0;
      format_locked  <= 1'b0;
    end else begin
      state          <= state_d;
      mute_cnt       <= mute_d;
      tmo_cnt        <= tmo_d;
      frame_cnt      <= frame_d;
      cand           <= cand_d;
      locked_format  <= lf_d;
      relock_count   <= rc_d;
      video_oe_x_out <= oe_d;
      norm_y_g       <= norm_d;
      format_locked  <= (state_d == LOCKED);
    end
  end

endmodule
